// File: rtl/buck_current_pi.sv
// buck_current_pi: pipelined PI current loop, i_set/i_meas -> buck duty.
// Ports: clk, rst (async high), enable, i_set, i_meas, sample_valid,
//   kp, ki (unsigned Q.FRAC_BITS) -> duty, duty_valid, sat_hi, sat_lo.
// Define BUCK_PI_ANTIWINDUP_EN for conditional integration.
module buck_current_pi #(
  parameter int                 FRAC_BITS = 8,
  parameter logic signed [31:0] INT_LIM   = 32'sd65535,
  parameter int                 DUTY_W    = 12,
  parameter int                 DUTY_MAX  = 4000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [15:0]       i_set,
  input  logic [15:0]       i_meas,
  input  logic              sample_valid,
  input  logic [15:0]       kp,
  input  logic [15:0]       ki,
  output logic [DUTY_W-1:0] duty,
  output logic              duty_valid,
  output logic              sat_hi,
  output logic              sat_lo
);

  localparam logic signed [33:0] LIM  = 34'(INT_LIM);
  localparam logic signed [33:0] NLIM = -LIM;
  localparam logic signed [34:0] DMAX = 35'(DUTY_MAX);

  logic                cap_v;
  logic [15:0]         cap_set;
  logic [15:0]         cap_meas;

  logic                s1_v;
  logic signed [16:0]  s1_err;

  logic                s2_v;
  logic signed [33:0]  s2_p;
  logic signed [33:0]  s2_inc;

  logic                s3_v;
  logic signed [33:0]  s3_p;
  logic signed [33:0]  integ;

  logic signed [16:0]  err_c;
  logic signed [33:0]  err_x;
  logic signed [33:0]  prod_p;
  logic signed [33:0]  prod_i;
  logic signed [33:0]  integ_sum;
  logic signed [33:0]  integ_nxt;
  logic signed [34:0]  sum_c;
  logic                hold;
  logic                hi_c;
  logic                lo_c;

  assign err_c = $signed({1'b0, cap_set})
               - $signed({1'b0, cap_meas});

  assign err_x  = $signed({{17{s1_err[16]}}, s1_err});
  assign prod_p = err_x * $signed({18'd0, kp});
  assign prod_i = err_x * $signed({18'd0, ki});

`ifdef BUCK_PI_ANTIWINDUP_EN
  // Freeze integration while pushing further into the active clamp.
  assign hold = (sat_hi && !s2_inc[33] && (|s2_inc))
             || (sat_lo && s2_inc[33]);
`else
  assign hold = 1'b0;
`endif

  always_comb begin
    integ_sum = integ + s2_inc;
    integ_nxt = integ_sum;
    if (integ_sum > LIM) begin
      integ_nxt = LIM;
    end else if (integ_sum < NLIM) begin
      integ_nxt = NLIM;
    end
    if (hold) begin
      integ_nxt = integ;
    end
  end

  assign sum_c = {s3_p[33], s3_p} + {integ[33], integ};
  assign hi_c  = sum_c > DMAX;
  assign lo_c  = sum_c[34];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_v    <= 1'b0;
      cap_set  <= '0;
      cap_meas <= '0;
    end else if (!enable) begin
      cap_v    <= 1'b0;
    end else begin
      cap_v <= sample_valid;
      if (sample_valid) begin
        cap_set  <= i_set;
        cap_meas <= i_meas;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v   <= 1'b0;
      s1_err <= '0;
    end else if (!enable) begin
      s1_v   <= 1'b0;
    end else begin
      s1_v <= cap_v;
      if (cap_v) begin
        s1_err <= err_c;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_v   <= 1'b0;
      s2_p   <= '0;
      s2_inc <= '0;
    end else if (!enable) begin
      s2_v   <= 1'b0;
    end else begin
      s2_v <= s1_v;
      if (s1_v) begin
        s2_p   <= prod_p >>> FRAC_BITS;
        s2_inc <= prod_i >>> FRAC_BITS;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s3_v  <= 1'b0;
      s3_p  <= '0;
      integ <= '0;
    end else if (!enable) begin
      s3_v  <= 1'b0;
      integ <= '0;
    end else begin
      s3_v <= s2_v;
      if (s2_v) begin
        s3_p  <= s2_p;
        integ <= integ_nxt;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty       <= '0;
      duty_valid <= 1'b0;
      sat_hi     <= 1'b0;
      sat_lo     <= 1'b0;
    end else if (!enable) begin
      duty       <= '0;
      duty_valid <= 1'b0;
      sat_hi     <= 1'b0;
      sat_lo     <= 1'b0;
    end else begin
      duty_valid <= s3_v;
      if (s3_v) begin
        unique case (1'b1)
          hi_c: begin
            duty   <= DUTY_W'(DUTY_MAX);
            sat_hi <= 1'b1;
            sat_lo <= 1'b0;
          end
          lo_c: begin
            duty   <= '0;
            sat_hi <= 1'b0;
            sat_lo <= 1'b1;
          end
          default: begin
            duty   <= sum_c[DUTY_W-1:0];
            sat_hi <= 1'b0;
            sat_lo <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_buck_current_pi.sv
// tb_buck_current_pi: directed + randomized checks of buck_current_pi.
// Reference model works on whole samples with plain integer arithmetic.
module tb_buck_current_pi;

`ifdef BUCK_PI_ANTIWINDUP_EN
  localparam bit AW = 1'b1;
`else
  localparam bit AW = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] i_set;
  logic [15:0] i_meas;
  logic        sample_valid;
  logic [15:0] kp;
  logic [15:0] ki;
  logic [11:0] duty;
  logic        duty_valid;
  logic        sat_hi;
  logic        sat_lo;

  int n_checks = 0;
  int n_fail   = 0;
  int cycles   = 0;

  typedef struct {
    int cyc;
    int duty;
    bit hi;
    bit lo;
  } exp_t;

  exp_t   q[$];
  longint m_integ;
  bit     m_hi;
  bit     m_lo;
  bit     drv_done;

  buck_current_pi dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .i_set        (i_set),
    .i_meas       (i_meas),
    .sample_valid (sample_valid),
    .kp           (kp),
    .ki           (ki),
    .duty         (duty),
    .duty_valid   (duty_valid),
    .sat_hi       (sat_hi),
    .sat_lo       (sat_lo)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycles <= cycles + 1;

  function automatic longint fdiv(input longint a, input longint b);
    longint r;
    r = a / b;
    if ((a % b) != 0 && a < 0) r = r - 1;
    return r;
  endfunction

  function automatic void model(input int s, input int m,
                                input int gp, input int gi,
                                output int d, output bit hi,
                                output bit lo);
    longint err, p, inc, sum;
    bit h;
    err = longint'(s) - longint'(m);
    p   = fdiv(err * gp, 256);
    inc = fdiv(err * gi, 256);
    h   = AW && ((m_hi && inc > 0) || (m_lo && inc < 0));
    if (!h) begin
      m_integ = m_integ + inc;
      if (m_integ > 65535)  m_integ = 65535;
      if (m_integ < -65535) m_integ = -65535;
    end
    sum = p + m_integ;
    if (sum > 4000) begin
      d = 4000; hi = 1; lo = 0;
    end else if (sum < 0) begin
      d = 0; hi = 0; lo = 1;
    end else begin
      d = int'(sum); hi = 0; lo = 0;
    end
    m_hi = hi;
    m_lo = lo;
  endfunction

  task automatic strobe(input int s, input int m);
    @(negedge clk);
    i_set = 16'(s);
    i_meas = 16'(m);
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic wait_dv(output int lat);
    lat = -1;
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      @(negedge clk);
      if (duty_valid) lat = i;
    end
  endtask

  task automatic clear_loop();
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    m_integ = 0;
    m_hi = 0;
    m_lo = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    enable = 1'b1;
    sample_valid = 1'b1;
    i_set = 16'd3000;
    i_meas = 16'd0;
    kp = 16'h0100;
    ki = 16'h0100;
    repeat (6) @(negedge clk);
    n_checks++;
    if (duty !== 12'd0 || duty_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out duty=%0d dv=%b want 0/0",
               duty, duty_valid);
    end
    n_checks++;
    if (sat_hi !== 1'b0 || sat_lo !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_sat hi=%b lo=%b want 0/0", sat_hi, sat_lo);
    end
    sample_valid = 1'b0;
    rst = 1'b0;
    repeat (6) @(negedge clk);
    n_checks++;
    if (duty !== 12'd0 || duty_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset duty=%0d dv=%b want 0/0",
               duty, duty_valid);
    end
  endtask

  task automatic test_p_only();
    int lat;
    kp = 16'h0100;
    ki = 16'h0000;
    strobe(1000, 600);
    wait_dv(lat);
    n_checks++;
    if (lat != 4) begin
      n_fail++;
      $display("FAIL p_only_latency got %0d want 4", lat);
    end
    n_checks++;
    if (duty !== 12'd400 || sat_hi !== 1'b0 || sat_lo !== 1'b0) begin
      n_fail++;
      $display("FAIL p_only duty=%0d hi=%b lo=%b want 400/0/0",
               duty, sat_hi, sat_lo);
    end
    @(negedge clk);
    n_checks++;
    if (duty_valid !== 1'b0 || duty !== 12'd400) begin
      n_fail++;
      $display("FAIL p_only_hold dv=%b duty=%0d want 0/400",
               duty_valid, duty);
    end
  endtask

  task automatic test_pi_accum();
    int lat;
    clear_loop();
    kp = 16'h0100;
    ki = 16'h0080;
    for (int k = 0; k < 4; k++) begin
      strobe(1400, 1000);
      wait_dv(lat);
      n_checks++;
      if (lat != 4 || duty !== 12'(600 + 200 * k)) begin
        n_fail++;
        $display("FAIL pi_accum[%0d] lat=%0d duty=%0d want 4/%0d",
                 k, lat, duty, 600 + 200 * k);
      end
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic test_saturation();
    int lat;
    clear_loop();
    kp = 16'h0100;
    ki = 16'h0000;
    strobe(6000, 1000);
    wait_dv(lat);
    n_checks++;
    if (duty !== 12'd4000 || sat_hi !== 1'b1 || sat_lo !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_hi duty=%0d hi=%b lo=%b want 4000/1/0",
               duty, sat_hi, sat_lo);
    end
    strobe(100, 900);
    wait_dv(lat);
    n_checks++;
    if (duty !== 12'd0 || sat_hi !== 1'b0 || sat_lo !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_lo duty=%0d hi=%b lo=%b want 0/0/1",
               duty, sat_hi, sat_lo);
    end
    strobe(4000, 0);
    wait_dv(lat);
    n_checks++;
    if (duty !== 12'd4000 || sat_hi !== 1'b0 || sat_lo !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_edge duty=%0d hi=%b lo=%b want 4000/0/0",
               duty, sat_hi, sat_lo);
    end
  endtask

  task automatic test_back_to_back();
    clear_loop();
    kp = 16'h0100;
    ki = 16'h0000;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      i_set = 16'(1000 + 100 * k);
      i_meas = 16'd1000;
      sample_valid = 1'b1;
    end
    @(negedge clk);
    sample_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      n_checks++;
      if (k <= 4 && (duty_valid !== 1'b1 || duty !== 12'(100 * k))) begin
        n_fail++;
        $display("FAIL b2b[%0d] dv=%b duty=%0d want 1/%0d",
                 k, duty_valid, duty, 100 * k);
      end else if (k == 5 && duty_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_end dv=%b want 0", duty_valid);
      end
    end
  endtask

  task automatic test_enable_drop();
    int lat;
    int seen;
    kp = 16'h0100;
    ki = 16'h0080;
    strobe(1400, 1000);
    wait_dv(lat);
    n_checks++;
    if (duty !== 12'd600) begin
      n_fail++;
      $display("FAIL en_pre duty=%0d want 600", duty);
    end
    strobe(1400, 1000);
    seen = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (duty_valid) seen++;
      if (i == 1) enable = 1'b0;
      if (i == 2) begin
        i_set = 16'd3000;
        sample_valid = 1'b1;
      end
      if (i == 3) sample_valid = 1'b0;
      if (i == 4) enable = 1'b1;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL en_drop_dv got %0d strobes want 0", seen);
    end
    n_checks++;
    if (duty !== 12'd0 || sat_hi !== 1'b0 || sat_lo !== 1'b0) begin
      n_fail++;
      $display("FAIL en_drop_clr duty=%0d hi=%b lo=%b want 0/0/0",
               duty, sat_hi, sat_lo);
    end
    strobe(1400, 1000);
    wait_dv(lat);
    n_checks++;
    if (lat != 4 || duty !== 12'd600) begin
      n_fail++;
      $display("FAIL en_restart lat=%0d duty=%0d want 4/600", lat, duty);
    end
  endtask

  task automatic test_antiwindup();
    int lat;
    clear_loop();
    kp = 16'h0100;
    ki = 16'h0100;
    for (int k = 0; k < 5; k++) begin
      strobe(4000, 1000);
      wait_dv(lat);
      n_checks++;
      if (duty !== 12'd4000 || sat_hi !== 1'b1) begin
        n_fail++;
        $display("FAIL aw_sat[%0d] duty=%0d hi=%b want 4000/1",
                 k, duty, sat_hi);
      end
      repeat (4) @(negedge clk);
    end
    strobe(1000, 2000);
    wait_dv(lat);
    n_checks++;
    if (AW && (duty !== 12'd1000 || sat_hi !== 1'b0)) begin
      n_fail++;
      $display("FAIL aw_release duty=%0d hi=%b want 1000/0",
               duty, sat_hi);
    end else if (!AW && (duty !== 12'd4000 || sat_hi !== 1'b1)) begin
      n_fail++;
      $display("FAIL windup duty=%0d hi=%b want 4000/1", duty, sat_hi);
    end
  endtask

  task automatic test_random();
    clear_loop();
    drv_done = 1'b0;
    fork
      begin
        for (int b = 0; b < 4; b++) begin
          for (int w = 0; w < 100 && q.size() != 0; w++)
            @(negedge clk);
          @(negedge clk);
          kp = 16'($urandom_range(0, 1023));
          ki = 16'($urandom_range(0, 255));
          for (int n = 0; n < 20; n++) begin
            exp_t e;
            int s, m, gap;
            s = $urandom_range(0, 9000);
            m = $urandom_range(0, 9000);
            if ($urandom_range(0, 9) == 0) s = 0;
            if ($urandom_range(0, 9) == 0) m = 65535;
            gap = AW ? $urandom_range(5, 8) : $urandom_range(1, 6);
            model(s, m, int'(kp), int'(ki), e.duty, e.hi, e.lo);
            e.cyc = cycles + 5;
            q.push_back(e);
            i_set = 16'(s);
            i_meas = 16'(m);
            sample_valid = 1'b1;
            @(negedge clk);
            sample_valid = 1'b0;
            repeat (gap - 1) @(negedge clk);
          end
        end
        drv_done = 1'b1;
      end
      begin
        for (int t = 0; t < 5000 && !(drv_done && q.size() == 0); t++) begin
          @(negedge clk);
          if (duty_valid) begin
            n_checks++;
            if (q.size() == 0) begin
              n_fail++;
              $display("FAIL rnd_extra duty_valid at cycle %0d", cycles);
            end else begin
              exp_t e;
              e = q.pop_front();
              if (e.cyc != cycles || duty !== 12'(e.duty)
                  || sat_hi !== e.hi || sat_lo !== e.lo) begin
                n_fail++;
                $display("FAIL rnd cyc=%0d duty=%0d hi=%b lo=%b want cyc=%0d %0d/%b/%b",
                         cycles, duty, sat_hi, sat_lo,
                         e.cyc, e.duty, e.hi, e.lo);
              end
            end
          end else if (q.size() != 0 && q[0].cyc < cycles) begin
            n_checks++;
            n_fail++;
            $display("FAIL rnd_missing due cyc=%0d now %0d", q[0].cyc, cycles);
            void'(q.pop_front());
          end
        end
      end
    join
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL rnd_timeout %0d outstanding want 0", q.size());
    end
  endtask

  initial begin
    test_reset();
    test_p_only();
    test_pi_accum();
    test_saturation();
    test_back_to_back();
    test_enable_drop();
    test_antiwindup();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
